branch_resolve_unit: RTL and testbench

Parametrised branch resolution stage for the RISC-V core: evaluates the branch condition selected by `b_control` on two XLEN-bit operands and computes the branch target. It trains a bimodal table of 2-bit saturating counters and flags mispredictions against the fetch-stage guess. It sits at the execute/memory boundary, registers its result one cycle after issue, and drives the redirect/flush path back to fetch.

---
 rtl/branch_resolve_unit.sv | 184 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Branch resolution stage at the execute/memory boundary. It evaluates the
// branch condition chosen by b_control on r1/r2, computes the branch target
// and the redirect PC, and registers the result one cycle after issue. A
// bimodal table of 2-bit saturating counters is trained on every resolved
// conditional branch and read combinationally by fetch. A saturating counter
// tallies mispredictions.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid, flush   branch present this cycle / kill it before capture
//   b_control         condition select (none, BEQ..BGEU, JAL)
//   r1, r2            source operands
//   in_pc, imm        PC of the branch and its sign-extended offset
//   pred_taken        fetch-stage guess for this branch
//   lookup_pc         fetch-side PC to predict
//   lookup_taken      prediction for lookup_pc (counter MSB, combinational)
//   out_valid         registered result valid
//   branch_sel        branch actually taken
//   target            in_pc + imm
//   mispredict        branch_sel != pred_taken, qualified by out_valid
//   redirect_pc       target if taken, else in_pc + 4
//   mispredict_count  saturating count of mispredictions
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             flush,
    input  logic [2:0]       b_control,
    input  logic [XLEN-1:0]  r1,
    input  logic [XLEN-1:0]  r2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             lookup_taken,
    output logic             out_valid,
    output logic             branch_sel,
    output logic [XLEN-1:0]  target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BGE  = 3'b100,
        BR_BLTU = 3'b101,
        BR_BGEU = 3'b110,
        BR_JAL  = 3'b111
    } b_op_e;

    localparam logic [1:0] CNT_WEAK_NT = 2'b01;

    b_op_e op;
    assign op = b_op_e'(b_control);

    logic             out_valid_q,   out_valid_d;
    logic             branch_sel_q,  branch_sel_d;
    logic             mispredict_q,  mispredict_d;
    logic [XLEN-1:0]  target_q,      target_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] mcount_q,      mcount_d;
    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_d [BHT_ENTRIES];

    logic             issue;
    logic             taken;
    logic             is_cond;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lk_idx;
    logic [XLEN-1:0]  sum_target;

    assign issue      = in_valid & ~flush;
    assign upd_idx    = in_pc[IDX_W+1:2];
    assign lk_idx     = lookup_pc[IDX_W+1:2];
    assign sum_target = in_pc + imm;

    // Only the index slice of lookup_pc selects a counter.
    logic unused_lookup_bits;
    assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

    // Pre-update value: an update in this cycle only shows after the edge.
    assign lookup_taken = bht_q[lk_idx][1];

    // Condition evaluation.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        taken   = 1'b0;
        is_cond = 1'b1;
        unique case (op)
            BR_NONE: is_cond = 1'b0;
            BR_BEQ:  taken = (r1 == r2);
            BR_BNE:  taken = (r1 != r2);
            BR_BLT:  taken = ($signed(r1) <  $signed(r2));
            BR_BGE:  taken = ($signed(r1) >= $signed(r2));
            BR_BLTU: taken = (r1 <  r2);
            BR_BGEU: taken = (r1 >= r2);
            BR_JAL:  begin
                taken   = 1'b1;
                is_cond = 1'b0;
            end
            default: is_cond = 1'b0;
        endcase
    end

    // Next-state logic for the result register, the BHT and the counter.
    always_comb begin
        out_valid_d   = issue;
        branch_sel_d  = issue & taken;
        mispredict_d  = issue & (taken != pred_taken);
        target_d      = target_q;
        redirect_pc_d = redirect_pc_q;
        if (issue) begin
            target_d      = sum_target;
            redirect_pc_d = taken ? sum_target : (in_pc + XLEN'(4));
        end

        bht_d = bht_q;
        // JAL and "none" carry no direction information worth learning.
        if (issue && is_cond) begin
            if (taken && bht_q[upd_idx] != 2'b11) begin
                bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
            end else if (!taken && bht_q[upd_idx] != 2'b00) begin
                bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
            end
        end

        // Counts the mispredict currently on the outputs; holds at all-ones.
        mcount_d = mcount_q;
        if (out_valid_q && mispredict_q && !(&mcount_q)) begin
            mcount_d = mcount_q + CNT_W'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            branch_sel_q  <= 1'b0;
            mispredict_q  <= 1'b0;
            target_q      <= '0;
            redirect_pc_q <= '0;
            mcount_q      <= '0;
            // NOTE: the BHT is a register array, not RAM, so it can and must be
            // reset: predictions have to start from a known weak-NT state.
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CNT_WEAK_NT;
            end
        end else begin
            out_valid_q   <= out_valid_d;
            branch_sel_q  <= branch_sel_d;
            mispredict_q  <= mispredict_d;
            target_q      <= target_d;
            redirect_pc_q <= redirect_pc_d;
            mcount_q      <= mcount_d;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= bht_d[i];
            end
        end
    end

    assign out_valid        = out_valid_q;
    assign branch_sel       = branch_sel_q;
    assign mispredict       = mispredict_q;
    assign target           = target_q;
    assign redirect_pc      = redirect_pc_q;
    assign mispredict_count = mcount_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed bench for branch_resolve_unit (XLEN=32, 64 BHT entries, CNT_W=2).
// Walks reset, every compare, BHT training and saturation, flush, JAL with
// PC wrap, the code-000 mispredict, counter saturation and a mid-stream reset.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int XLEN = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             flush;
    logic [2:0]       b_control;
    logic [XLEN-1:0]  r1, r2, in_pc, imm, lookup_pc;
    logic             pred_taken;
    logic             lookup_taken;
    logic             out_valid;
    logic             branch_sel;
    logic [XLEN-1:0]  target;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic [1:0]       mispredict_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .XLEN(XLEN), .BHT_ENTRIES(64), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .b_control(b_control), .r1(r1), .r2(r2), .in_pc(in_pc), .imm(imm),
        .pred_taken(pred_taken), .lookup_pc(lookup_pc),
        .lookup_taken(lookup_taken), .out_valid(out_valid),
        .branch_sel(branch_sel), .target(target), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .mispredict_count(mispredict_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one instruction before the edge, sample #1 after it.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] off, input logic pred,
                         input logic fl);
        b_control  = op;
        r1         = a;
        r2         = b;
        in_pc      = pc;
        imm        = off;
        pred_taken = pred;
        flush      = fl;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; b_control = 3'b000;
        r1 = '0; r2 = '0; in_pc = '0; imm = '0; pred_taken = 1'b0; lookup_pc = '0;

        // ---- Reset state ----
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_branch_sel", branch_sel, 0);
        check("rst_mispredict", mispredict, 0);
        check("rst_target", target, 0);
        check("rst_redirect", redirect_pc, 0);
        check("rst_count", mispredict_count, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            lookup_pc = 32'(i) << 2;
            #1;
            check("rst_lookup", lookup_taken, 0);
        end
        idle();
        check("idle_out_valid", out_valid, 0);

        // ---- Compare coverage (in_pc=0x204, imm=0x40, pred_taken=0) ----
        issue(3'b001, 32'hF0000000, 32'hF0000000, 32'h204, 32'h40, 1'b0, 1'b0);
        check("beq_valid", out_valid, 1);
        check("beq_sel", branch_sel, 1);
        check("beq_mis", mispredict, 1);
        check("beq_target", target, 32'h244);
        check("beq_redirect", redirect_pc, 32'h244);

        issue(3'b010, 32'hF0000000, 32'hF0000000, 32'h204, 32'h40, 1'b0, 1'b0);
        check("bne_sel", branch_sel, 0);
        check("bne_mis", mispredict, 0);
        check("bne_target", target, 32'h244);
        check("bne_redirect", redirect_pc, 32'h208);

        issue(3'b011, 32'hF0000000, 32'hF0000001, 32'h204, 32'h40, 1'b0, 1'b0);
        check("blt_sel", branch_sel, 1);
        issue(3'b101, 32'hF0000000, 32'hF0000001, 32'h204, 32'h40, 1'b0, 1'b0);
        check("bltu_sel", branch_sel, 1);
        issue(3'b100, 32'hF0000000, 32'hFFFFFFFF, 32'h204, 32'h40, 1'b0, 1'b0);
        check("bge_sel", branch_sel, 0);
        check("bge_redirect", redirect_pc, 32'h208);
        issue(3'b110, 32'hF0000000, 32'hFFFFFFFF, 32'h204, 32'h40, 1'b0, 1'b0);
        check("bgeu_sel", branch_sel, 0);
        // Opposite-sign operands separate signed from unsigned ordering.
        issue(3'b011, 32'h00000001, 32'hFFFFFFFF, 32'h204, 32'h40, 1'b0, 1'b0);
        check("blt_mixed", branch_sel, 0);
        issue(3'b101, 32'h00000001, 32'hFFFFFFFF, 32'h204, 32'h40, 1'b0, 1'b0);
        check("bltu_mixed", branch_sel, 1);
        idle();
        check("one_cycle_valid", out_valid, 0);

        // ---- Code 000 with pred_taken=1 ----
        issue(3'b000, 32'h5, 32'h5, 32'h300, 32'h40, 1'b1, 1'b0);
        check("none_sel", branch_sel, 0);
        check("none_mis", mispredict, 1);
        check("none_redirect", redirect_pc, 32'h304);

        // ---- BHT training at 0x100 ----
        do_reset();
        lookup_pc = 32'h100;
        b_control = 3'b001; r1 = 32'h7; r2 = 32'h7; in_pc = 32'h100; in_valid = 1'b1;
        #1;
        check("bht_pre_update", lookup_taken, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bht_t1", lookup_taken, 1);        // 01 -> 10
        issue(3'b001, 32'h7, 32'h7, 32'h100, 32'h8, 1'b0, 1'b0);
        check("bht_t2", lookup_taken, 1);        // 10 -> 11
        issue(3'b001, 32'h7, 32'h7, 32'h100, 32'h8, 1'b0, 1'b0);
        check("bht_t3", lookup_taken, 1);        // stays 11
        issue(3'b001, 32'h7, 32'h6, 32'h100, 32'h8, 1'b0, 1'b0);
        check("bht_nt1", lookup_taken, 1);       // 11 -> 10
        issue(3'b001, 32'h7, 32'h6, 32'h100, 32'h8, 1'b0, 1'b0);
        check("bht_nt2", lookup_taken, 0);       // 10 -> 01, proves saturation at 11

        // ---- Flush blocks capture and training ----
        issue(3'b001, 32'h7, 32'h7, 32'h100, 32'h8, 1'b0, 1'b1);
        check("flush_valid", out_valid, 0);
        check("flush_mis", mispredict, 0);
        check("flush_bht", lookup_taken, 0);

        // ---- JAL with PC wrap ----
        lookup_pc = 32'hFFFFFFFC;
        issue(3'b111, 32'h0, 32'h1, 32'hFFFFFFFC, 32'h8, 1'b0, 1'b0);
        check("jal_sel", branch_sel, 1);
        check("jal_target", target, 32'h4);
        check("jal_redirect", redirect_pc, 32'h4);
        check("jal_bht", lookup_taken, 0);

        // ---- Mispredict counter saturation (CNT_W=2) ----
        do_reset();
        lookup_pc = 32'h100;
        for (int k = 1; k <= 5; k++) begin
            issue(3'b001, 32'h9, 32'h9, 32'h100, 32'h10, 1'b0, 1'b0);
            check("cnt_mis", mispredict, 1);
            check("cnt_value", mispredict_count, (k - 1 > 3) ? 3 : k - 1);
        end
        idle();
        check("cnt_final", mispredict_count, 3);
        check("cnt_bht_sat", lookup_taken, 1);

        // ---- Mid-stream reset ----
        issue(3'b001, 32'h9, 32'h9, 32'h100, 32'h10, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_sel", branch_sel, 0);
        check("mrst_mis", mispredict, 0);
        check("mrst_target", target, 0);
        check("mrst_redirect", redirect_pc, 0);
        check("mrst_count", mispredict_count, 0);
        check("mrst_lookup", lookup_taken, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
